alarm_controller: RTL and testbench

- Downstream consumer of the 12-hour BCD time-of-day counter (hh/mm/ss/pm plus its 1 Hz ena tick).
- Holds a programmable alarm time and compares it against the running clock.
- Drives a ring output through a 4-state FSM with snooze, stop and auto-timeout.
- Sits between the timekeeping core and the buzzer/indicator logic.

---
 rtl/alarm_controller.sv | 198 +++++++++++++++++++
 tb/tb_alarm_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm comparator and ring sequencer fed by the 12-hour BCD time-of-day counter.
// Holds a validated alarm time and drives ring/snooze/stop with an auto-timeout.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | alarm disabled (arm low), all counters cleared
// ARMED    | waiting for the running time to hit the alarm minute
// RINGING  | ring asserted; counting seconds toward auto-stop
// SNOOZE   | ring paused; counting down the snooze interval
module alarm_controller #(
    parameter int SNOOZE_MIN = 9,
    parameter int RING_MAX_S = 60,
    parameter int SNOOZE_MAX = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    input  logic [7:0]                            hh,
    input  logic [7:0]                            mm,
    input  logic [7:0]                            ss,
    input  logic                                  pm,
    input  logic                                  set_en,
    input  logic [7:0]                            set_hh,
    input  logic [7:0]                            set_mm,
    input  logic                                  set_pm,
    input  logic                                  arm,
    input  logic                                  snooze_btn,
    input  logic                                  stop_btn,
    output logic                                  ring,
    output logic                                  armed,
    output logic                                  snoozing,
    output logic [$clog2(SNOOZE_MAX+1)-1:0]       snooze_cnt,
    output logic                                  set_err,
    output logic [7:0]                            alarm_hh,
    output logic [7:0]                            alarm_mm,
    output logic                                  alarm_pm
);

    localparam int SC_W = $clog2(SNOOZE_MAX + 1);
    localparam int CD_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam int RS_W = $clog2(RING_MAX_S + 1);

    localparam logic [SC_W-1:0] SNOOZE_LIMIT = SC_W'(SNOOZE_MAX);
    localparam logic [CD_W-1:0] SNOOZE_LOAD  = CD_W'(SNOOZE_MIN * 60);
    localparam logic [RS_W-1:0] RING_LAST    = RS_W'(RING_MAX_S - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [RS_W-1:0] ring_sec_q, ring_sec_d;
    logic [CD_W-1:0] countdown_q, countdown_d;
    logic [SC_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic [7:0]      alarm_hh_q, alarm_hh_d;
    logic [7:0]      alarm_mm_q, alarm_mm_d;
    logic            alarm_pm_q, alarm_pm_d;
    logic            set_err_q, set_err_d;
    logic            snooze_btn_q, stop_btn_q;

    logic snooze_press;
    logic stop_press;
    logic set_hh_ok;
    logic set_mm_ok;
    logic set_ok;
    logic match;

    assign snooze_press = snooze_btn & ~snooze_btn_q;
    assign stop_press   = stop_btn & ~stop_btn_q;

    // Hour must be 01..09 or 10..12; minute 00..59 with both digits decimal.
    assign set_hh_ok = (set_hh[3:0] <= 4'd9) &&
                       (((set_hh[7:4] == 4'd0) && (set_hh[3:0] != 4'd0)) ||
                        ((set_hh[7:4] == 4'd1) && (set_hh[3:0] <= 4'd2)));
    assign set_mm_ok = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
    assign set_ok    = set_hh_ok && set_mm_ok;

    assign match = ena && arm && (pm == alarm_pm_q) && (hh == alarm_hh_q) &&
                   (mm == alarm_mm_q) && (ss == 8'h00);

    always_comb begin
        alarm_hh_d = alarm_hh_q;
        alarm_mm_d = alarm_mm_q;
        alarm_pm_d = alarm_pm_q;
        set_err_d  = 1'b0;
        if (set_en) begin
            if (set_ok) begin
                alarm_hh_d = set_hh;
                alarm_mm_d = set_mm;
                alarm_pm_d = set_pm;
            end else begin
                set_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_sec_d   = ring_sec_q;
        countdown_d  = countdown_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!arm) begin
            state_d      = ST_IDLE;
            ring_sec_d   = '0;
            countdown_d  = '0;
            snooze_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (match) begin
                        state_d      = ST_RINGING;
                        ring_sec_d   = '0;
                        snooze_cnt_d = '0;
                    end
                end
                ST_RINGING: begin
                    // Button actions are checked before the timeout so they win a tie.
                    if (stop_press) begin
                        state_d      = ST_ARMED;
                        ring_sec_d   = '0;
                        snooze_cnt_d = '0;
                    end else if (snooze_press && (snooze_cnt_q < SNOOZE_LIMIT)) begin
                        state_d      = ST_SNOOZE;
                        ring_sec_d   = '0;
                        countdown_d  = SNOOZE_LOAD;
                        snooze_cnt_d = snooze_cnt_q + SC_W'(1);
                    end else if (ena) begin
                        if (ring_sec_q == RING_LAST) begin
                            state_d      = ST_ARMED;
                            ring_sec_d   = '0;
                            snooze_cnt_d = '0;
                        end else begin
                            ring_sec_d = ring_sec_q + RS_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_press) begin
                        state_d      = ST_ARMED;
                        countdown_d  = '0;
                        snooze_cnt_d = '0;
                    end else if (ena) begin
                        if (countdown_q == CD_W'(1)) begin
                            state_d     = ST_RINGING;
                            ring_sec_d  = '0;
                            countdown_d = '0;
                        end else begin
                            countdown_d = countdown_q - CD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ring_sec_q   <= '0;
            countdown_q  <= '0;
            snooze_cnt_q <= '0;
            alarm_hh_q   <= 8'h12;
            alarm_mm_q   <= 8'h00;
            alarm_pm_q   <= 1'b0;
            set_err_q    <= 1'b0;
            snooze_btn_q <= 1'b0;
            stop_btn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_sec_q   <= ring_sec_d;
            countdown_q  <= countdown_d;
            snooze_cnt_q <= snooze_cnt_d;
            alarm_hh_q   <= alarm_hh_d;
            alarm_mm_q   <= alarm_mm_d;
            alarm_pm_q   <= alarm_pm_d;
            set_err_q    <= set_err_d;
            snooze_btn_q <= snooze_btn;
            stop_btn_q   <= stop_btn;
        end
    end

    assign ring       = (state_q == ST_RINGING);
    assign snoozing   = (state_q == ST_SNOOZE);
    assign armed      = (state_q != ST_IDLE);
    assign snooze_cnt = snooze_cnt_q;
    assign set_err    = set_err_q;
    assign alarm_hh   = alarm_hh_q;
    assign alarm_mm   = alarm_mm_q;
    assign alarm_pm   = alarm_pm_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: a behavioural 12-hour clock drives the DUT,
// expected outputs go through a scoreboard queue and are checked with immediate asserts.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] hh, mm, ss;
    logic       pm;
    logic       set_en = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic       set_pm = 1'b0;
    logic       arm = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       ring, armed, snoozing, set_err, alarm_pm;
    logic [1:0] snooze_cnt;
    logic [7:0] alarm_hh, alarm_mm;

    int   t_h = 12;
    int   t_m = 0;
    int   t_s = 0;
    logic t_pm = 1'b0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alarm_controller #(
        .SNOOZE_MIN (1),
        .RING_MAX_S (5),
        .SNOOZE_MAX (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ena        (ena),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .pm         (pm),
        .set_en     (set_en),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_pm     (set_pm),
        .arm        (arm),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .ring       (ring),
        .armed      (armed),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt),
        .set_err    (set_err),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .alarm_pm   (alarm_pm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    always_comb begin
        hh = to_bcd(t_h);
        mm = to_bcd(t_m);
        ss = to_bcd(t_s);
        pm = t_pm;
    end

    task automatic push(input string tag, input logic [7:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic push_status(input string step, input logic r, input logic a,
                               input logic s, input logic [1:0] c);
        push({step, ".ring"}, {7'd0, r});
        push({step, ".armed"}, {7'd0, a});
        push({step, ".snoozing"}, {7'd0, s});
        push({step, ".snooze_cnt"}, {6'd0, c});
    endtask

    task automatic check_status();
        check({7'd0, ring});
        check({7'd0, armed});
        check({7'd0, snoozing});
        check({6'd0, snooze_cnt});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic advance_time();
        t_s++;
        if (t_s == 60) begin
            t_s = 0;
            t_m++;
            if (t_m == 60) begin
                t_m = 0;
                t_h++;
                if (t_h == 12) t_pm = ~t_pm;
                if (t_h == 13) t_h = 1;
            end
        end
    endtask

    task automatic set_time(input int h, input int m, input int s, input logic p);
        t_h  = h;
        t_m  = m;
        t_s  = s;
        t_pm = p;
    endtask

    task automatic tick_ena();
        ena = 1'b1;
        @(posedge clk);
        #1;
        ena = 1'b0;
        advance_time();
    endtask

    // One cycle with the given button levels (and optionally the 1 Hz tick), then release.
    task automatic press(input logic snz, input logic stp, input logic with_ena);
        snooze_btn = snz;
        stop_btn   = stp;
        ena        = with_ena;
        @(posedge clk);
        #1;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        ena        = 1'b0;
        if (with_ena) advance_time();
    endtask

    task automatic set_alarm(input logic [7:0] h, input logic [7:0] m, input logic p);
        set_en = 1'b1;
        set_hh = h;
        set_mm = m;
        set_pm = p;
        @(posedge clk);
        #1;
        set_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        cyc(2);
        push_status("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        check_status();
        push("reset.alarm_hh", 8'h12); check(alarm_hh);
        push("reset.alarm_mm", 8'h00); check(alarm_mm);
        push("reset.alarm_pm", 8'h00); check({7'd0, alarm_pm});
        push("reset.set_err", 8'h00);  check({7'd0, set_err});
        reset_n = 1'b1;
        cyc(1);

        // Validation
        set_alarm(8'h13, 8'h30, 1'b1);
        push("bad_hh.set_err", 8'h01);  check({7'd0, set_err});
        push("bad_hh.alarm_hh", 8'h12); check(alarm_hh);
        cyc(1);
        push("bad_hh.pulse_end", 8'h00); check({7'd0, set_err});
        set_alarm(8'h07, 8'h5A, 1'b1);
        push("bad_mm.set_err", 8'h01);  check({7'd0, set_err});
        push("bad_mm.alarm_mm", 8'h00); check(alarm_mm);
        push("bad_mm.alarm_pm", 8'h00); check({7'd0, alarm_pm});
        cyc(1);
        set_alarm(8'h12, 8'h00, 1'b0);
        push("ok_1200.set_err", 8'h00); check({7'd0, set_err});
        push("ok_1200.alarm_hh", 8'h12); check(alarm_hh);
        set_alarm(8'h07, 8'h30, 1'b1);
        push("ok_0730.set_err", 8'h00); check({7'd0, set_err});
        push("ok_0730.alarm_hh", 8'h07); check(alarm_hh);
        push("ok_0730.alarm_mm", 8'h30); check(alarm_mm);
        push("ok_0730.alarm_pm", 8'h01); check({7'd0, alarm_pm});

        arm = 1'b1;
        cyc(1);
        push_status("arm", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Basic alarm and auto-timeout
        set_time(7, 29, 59, 1'b1);
        tick_ena();
        push_status("basic.pre", 1'b0, 1'b1, 1'b0, 2'd0); check_status();
        tick_ena();
        push_status("basic.ring", 1'b1, 1'b1, 1'b0, 2'd0); check_status();
        repeat (4) tick_ena();
        push_status("basic.ring4", 1'b1, 1'b1, 1'b0, 2'd0); check_status();
        tick_ena();
        push_status("basic.timeout", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Snooze sequence
        set_time(7, 30, 0, 1'b1);
        tick_ena();
        push_status("snz.ring", 1'b1, 1'b1, 1'b0, 2'd0); check_status();
        press(1'b1, 1'b0, 1'b0);
        push_status("snz.first", 1'b0, 1'b1, 1'b1, 2'd1); check_status();
        repeat (59) tick_ena();
        push_status("snz.59s", 1'b0, 1'b1, 1'b1, 2'd1); check_status();
        tick_ena();
        push_status("snz.60s", 1'b1, 1'b1, 1'b0, 2'd1); check_status();
        press(1'b1, 1'b0, 1'b0);
        push_status("snz.second", 1'b0, 1'b1, 1'b1, 2'd2); check_status();
        repeat (60) tick_ena();
        push_status("snz.reringing", 1'b1, 1'b1, 1'b0, 2'd2); check_status();
        press(1'b1, 1'b0, 1'b0);
        push_status("snz.third_ignored", 1'b1, 1'b1, 1'b0, 2'd2); check_status();
        press(1'b0, 1'b1, 1'b0);
        push_status("snz.stop", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Snooze on the same tick as the auto-timeout
        set_time(7, 30, 0, 1'b1);
        tick_ena();
        repeat (4) tick_ena();
        press(1'b1, 1'b0, 1'b1);
        push_status("tie.snooze_wins", 1'b0, 1'b1, 1'b1, 2'd1); check_status();
        press(1'b0, 1'b1, 1'b0);
        push_status("tie.stop_in_snooze", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Stop and snooze together
        set_time(7, 30, 0, 1'b1);
        tick_ena();
        press(1'b1, 1'b1, 1'b0);
        push_status("both.stop_wins", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Disarm while snoozing
        set_time(7, 30, 0, 1'b1);
        tick_ena();
        press(1'b1, 1'b0, 1'b0);
        repeat (3) tick_ena();
        arm = 1'b0;
        cyc(1);
        push_status("disarm", 1'b0, 1'b0, 1'b0, 2'd0); check_status();
        arm = 1'b1;
        cyc(1);
        push_status("rearm", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Midnight crossing and AM/PM distinction
        set_alarm(8'h12, 8'h00, 1'b0);
        set_time(11, 59, 59, 1'b1);
        tick_ena();
        push_status("midnight.pre", 1'b0, 1'b1, 1'b0, 2'd0); check_status();
        tick_ena();
        push_status("midnight.ring", 1'b1, 1'b1, 1'b0, 2'd0); check_status();
        press(1'b0, 1'b1, 1'b0);
        set_alarm(8'h12, 8'h00, 1'b1);
        set_time(11, 59, 59, 1'b1);
        tick_ena();
        tick_ena();
        push_status("noon_alarm_at_midnight", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        // Asynchronous reset while ringing
        set_time(11, 59, 59, 1'b0);
        tick_ena();
        tick_ena();
        push_status("noon.ring", 1'b1, 1'b1, 1'b0, 2'd0); check_status();
        arm = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        push_status("async_rst", 1'b0, 1'b0, 1'b0, 2'd0); check_status();
        push("async_rst.alarm_pm", 8'h00); check({7'd0, alarm_pm});
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        push_status("post_rst", 1'b0, 1'b0, 1'b0, 2'd0); check_status();
        push("post_rst.alarm_hh", 8'h12); check(alarm_hh);
        push("post_rst.alarm_mm", 8'h00); check(alarm_mm);
        arm = 1'b1;
        cyc(1);
        push_status("post_rst.arm", 1'b0, 1'b1, 1'b0, 2'd0); check_status();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
